// File: rtl/offchip_mem_pkg.sv
// Package: offchip_mem_pkg
// Shared definitions for the off-chip memory bridge.
//  - state_e   : bridge FSM state encoding (idle, setup, access, hold)
//  - MIN_WAIT  : smallest legal access wait (in cycles)
//  - even_parity: even-parity bit of a zero-extended word
package offchip_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StHold   = 2'd3
    } state_e;

    localparam int MIN_WAIT  = 1;
    localparam int PAR_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/offchip_mem_bridge_if.sv
// Interface: offchip_mem_bridge_if
// Core-side request/response bundle of the off-chip memory bridge.
//  core_req/core_we/core_addr/core_wdata : request from the core
//  core_rdata/core_ack/core_busy         : response from the bridge
// Modports: master (core side), slave (bridge side).
interface offchip_mem_bridge_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ack;
    logic              core_busy;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_ack, core_busy
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_ack, core_busy
    );
endinterface

// File: rtl/pad_io_reg.sv
// Module: pad_io_reg
// Registered pad stage of the off-chip memory bridge.
//  clk_i, rst_i      : clock, synchronous active-high reset
//  load_i            : capture addr_i/wdata_i into the pad-side flops
//  addr_i, wdata_i   : request address and write data
//  pad_din_i         : raw read data from the pads
//  pad_addr_o        : registered pad address
//  pad_dout_o        : registered pad write data
//  din_q_o           : pad_din_i registered every cycle
// With OFFCHIP_MEM_PARITY_EN defined:
//  pad_par_in_i      : raw parity bit from the pads
//  pad_par_out_o     : even parity of pad_dout_o, loaded alongside it
//  par_in_q_o        : pad_par_in_i registered every cycle
module pad_io_reg
    import offchip_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] pad_din_i,
    output logic [ADDR_W-1:0] pad_addr_o,
    output logic [DATA_W-1:0] pad_dout_o,
    output logic [DATA_W-1:0] din_q_o
`ifdef OFFCHIP_MEM_PARITY_EN
    ,
    input  logic              pad_par_in_i,
    output logic              pad_par_out_o,
    output logic              par_in_q_o
`endif
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] din_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            dout_q <= '0;
            din_q  <= '0;
        end else begin
            din_q <= pad_din_i;
            if (load_i) begin
                addr_q <= addr_i;
                dout_q <= wdata_i;
            end
        end
    end

    assign pad_addr_o = addr_q;
    assign pad_dout_o = dout_q;
    assign din_q_o    = din_q;

`ifdef OFFCHIP_MEM_PARITY_EN
    logic par_out_q;
    logic par_in_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_out_q <= 1'b0;
            par_in_q  <= 1'b0;
        end else begin
            par_in_q <= pad_par_in_i;
            if (load_i) begin
                par_out_q <= even_parity(PAR_MAX_W'(wdata_i));
            end
        end
    end

    assign pad_par_out_o = par_out_q;
    assign par_in_q_o    = par_in_q;
`endif

endmodule

// File: rtl/offchip_mem_bridge.sv
// Module: offchip_mem_bridge
// Off-chip memory bridge between the CPU core and the pad ring. Accepts one
// request at a time and sequences it IDLE -> SETUP -> ACCESS (WAIT_CYC cycles)
// -> HOLD -> IDLE onto registered pad address/data/strobe signals.
//  c, r        : clock, synchronous active-high reset
//  core        : core-side request/response bundle (slave modport)
//  pad_addr    : registered address to pads
//  pad_dout    : registered write data to pads
//  pad_din     : read data from pads (always registered before use)
//  pad_cs      : chip select (SETUP and ACCESS)
//  pad_we      : write strobe (ACCESS, writes only)
//  pad_oe      : data-pad drive enable (SETUP..HOLD, writes only)
// Optional feature macro OFFCHIP_MEM_PARITY_EN adds pad_par_out, pad_par_in
// and core_perr (read parity error, pulses with core_ack).
module offchip_mem_bridge
    import offchip_mem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              c,
    input  logic              r,
    offchip_mem_bridge_if.slave core,
    output logic [ADDR_W-1:0] pad_addr,
    output logic [DATA_W-1:0] pad_dout,
    input  logic [DATA_W-1:0] pad_din,
    output logic              pad_cs,
    output logic              pad_we,
    output logic              pad_oe
`ifdef OFFCHIP_MEM_PARITY_EN
    ,
    output logic              pad_par_out,
    input  logic              pad_par_in,
    output logic              core_perr
`endif
);

    if (WAIT_CYC < MIN_WAIT) begin : g_wait_chk
        $error("offchip_mem_bridge: WAIT_CYC must be >= %0d", MIN_WAIT);
    end

    localparam int              CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              cs_q;
    logic              pwe_q;
    logic              oe_q;
    logic              load;
    logic [DATA_W-1:0] din_q;

    // Capture only in IDLE; a request still high in HOLD waits for IDLE.
    assign load = (state_q == StIdle) && core.core_req;

`ifdef OFFCHIP_MEM_PARITY_EN
    logic par_in_q;
    logic perr_q;
`endif

    pad_io_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_pad_io_reg (
        .clk_i         (c),
        .rst_i         (r),
        .load_i        (load),
        .addr_i        (core.core_addr),
        .wdata_i       (core.core_wdata),
        .pad_din_i     (pad_din),
        .pad_addr_o    (pad_addr),
        .pad_dout_o    (pad_dout),
        .din_q_o       (din_q)
`ifdef OFFCHIP_MEM_PARITY_EN
        ,
        .pad_par_in_i  (pad_par_in),
        .pad_par_out_o (pad_par_out),
        .par_in_q_o    (par_in_q)
`endif
    );

    // Pad strobes and ack are set on the edge entering the state they belong
    // to, so every output comes straight from a flop.
    always_ff @(posedge c) begin
        if (r) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            cs_q    <= 1'b0;
            pwe_q   <= 1'b0;
            oe_q    <= 1'b0;
`ifdef OFFCHIP_MEM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef OFFCHIP_MEM_PARITY_EN
            perr_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (core.core_req) begin
                        we_q    <= core.core_we;
                        cs_q    <= 1'b1;
                        oe_q    <= core.core_we;
                        pwe_q   <= 1'b0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    cnt_q   <= CNT_LOAD;
                    pwe_q   <= we_q;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (cnt_q == '0) begin
                        cs_q    <= 1'b0;
                        pwe_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= StHold;
                        if (!we_q) begin
                            rdata_q <= din_q;
`ifdef OFFCHIP_MEM_PARITY_EN
                            perr_q  <= even_parity(PAR_MAX_W'({par_in_q, din_q}));
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StHold: begin
                    oe_q    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core.core_rdata = rdata_q;
    assign core.core_ack   = ack_q;
    assign core.core_busy  = (state_q != StIdle);
    assign pad_cs          = cs_q;
    assign pad_we          = pwe_q;
    assign pad_oe          = oe_q;
`ifdef OFFCHIP_MEM_PARITY_EN
    assign core_perr       = perr_q;
`endif

endmodule

// File: tb/tb_offchip_mem_bridge.sv
// Directed bench for offchip_mem_bridge: three instances (WAIT_CYC = 2, 1, 7)
// share clock and reset; most steps drive the WAIT_CYC = 2 instance.
module tb_offchip_mem_bridge;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    offchip_mem_bridge_if #(.DATA_W(16), .ADDR_W(16)) b2 ();
    offchip_mem_bridge_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
    offchip_mem_bridge_if #(.DATA_W(16), .ADDR_W(16)) b7 ();

    logic [15:0] pad_addr2, pad_dout2, pad_din2;
    logic        pad_cs2, pad_we2, pad_oe2;
    logic [15:0] pad_addr1, pad_dout1, pad_din1;
    logic        pad_cs1, pad_we1, pad_oe1;
    logic [15:0] pad_addr7, pad_dout7, pad_din7;
    logic        pad_cs7, pad_we7, pad_oe7;
`ifdef OFFCHIP_MEM_PARITY_EN
    logic par_out2, par_in2, perr2;
    logic par_out1, par_in1, perr1;
    logic par_out7, par_in7, perr7;
`endif

    offchip_mem_bridge #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(2)) u_dut2 (
        .c(clk), .r(rst), .core(b2.slave),
        .pad_addr(pad_addr2), .pad_dout(pad_dout2), .pad_din(pad_din2),
        .pad_cs(pad_cs2), .pad_we(pad_we2), .pad_oe(pad_oe2)
`ifdef OFFCHIP_MEM_PARITY_EN
        , .pad_par_out(par_out2), .pad_par_in(par_in2), .core_perr(perr2)
`endif
    );

    offchip_mem_bridge #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(1)) u_dut1 (
        .c(clk), .r(rst), .core(b1.slave),
        .pad_addr(pad_addr1), .pad_dout(pad_dout1), .pad_din(pad_din1),
        .pad_cs(pad_cs1), .pad_we(pad_we1), .pad_oe(pad_oe1)
`ifdef OFFCHIP_MEM_PARITY_EN
        , .pad_par_out(par_out1), .pad_par_in(par_in1), .core_perr(perr1)
`endif
    );

    offchip_mem_bridge #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(7)) u_dut7 (
        .c(clk), .r(rst), .core(b7.slave),
        .pad_addr(pad_addr7), .pad_dout(pad_dout7), .pad_din(pad_din7),
        .pad_cs(pad_cs7), .pad_we(pad_we7), .pad_oe(pad_oe7)
`ifdef OFFCHIP_MEM_PARITY_EN
        , .pad_par_out(par_out7), .pad_par_in(par_in7), .core_perr(perr7)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int k1;
    int k7;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        b2.core_req = 1'b0; b2.core_we = 1'b0; b2.core_addr = '0; b2.core_wdata = '0;
        b1.core_req = 1'b0; b1.core_we = 1'b0; b1.core_addr = '0; b1.core_wdata = '0;
        b7.core_req = 1'b0; b7.core_we = 1'b0; b7.core_addr = '0; b7.core_wdata = '0;
        pad_din2 = '0; pad_din1 = '0; pad_din7 = '0;
`ifdef OFFCHIP_MEM_PARITY_EN
        par_in2 = 1'b0; par_in1 = 1'b0; par_in7 = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_pad_addr", 32'(pad_addr2), 32'h0);
        check("rst_pad_dout", 32'(pad_dout2), 32'h0);
        check("rst_strobes", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'h0);
        check("rst_rdata", 32'(b2.core_rdata), 32'h0);
        check("rst_ack_busy", {30'd0, b2.core_ack, b2.core_busy}, 32'h0);

        // Write 0xBEEF @ 0x0010
        b2.core_req = 1'b1; b2.core_we = 1'b1;
        b2.core_addr = 16'h0010; b2.core_wdata = 16'hBEEF;
        tick(); // SETUP
        check("wr_setup_cs_we_oe", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'b101);
        check("wr_setup_busy_ack", {30'd0, b2.core_busy, b2.core_ack}, 32'b10);
        check("wr_pad_addr", 32'(pad_addr2), 32'h0010);
        check("wr_pad_dout", 32'(pad_dout2), 32'hBEEF);
`ifdef OFFCHIP_MEM_PARITY_EN
        check("wr_par_out", 32'(par_out2), 32'h1);
`endif
        tick(); // ACCESS 1
        check("wr_acc1_cs_we_oe", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'b111);
        tick(); // ACCESS 2
        check("wr_acc2_cs_we_oe", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'b111);
        check("wr_acc2_ack", 32'(b2.core_ack), 32'h0);
        tick(); // HOLD
        check("wr_hold_cs_we_oe", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'b001);
        check("wr_hold_ack", 32'(b2.core_ack), 32'h1);
        check("wr_rdata_unchanged", 32'(b2.core_rdata), 32'h0);
        b2.core_req = 1'b0;
        tick(); // IDLE
        check("wr_idle_ack_busy", {30'd0, b2.core_ack, b2.core_busy}, 32'h0);
        check("wr_idle_strobes", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'h0);
        check("wr_idle_addr_held", 32'(pad_addr2), 32'h0010);
        check("wr_idle_dout_held", 32'(pad_dout2), 32'hBEEF);

        // Read @ 0x0020, pad_din = 0x1234 during the access
        pad_din2 = 16'hAAAA;
        b2.core_req = 1'b1; b2.core_we = 1'b0; b2.core_addr = 16'h0020;
        tick(); // SETUP
        pad_din2 = 16'h1234;
        check("rd_setup_cs_we_oe", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'b100);
        check("rd_pad_addr", 32'(pad_addr2), 32'h0020);
        tick(); // ACCESS 1
        check("rd_acc1_cs_we_oe", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'b100);
        tick(); // ACCESS 2
        tick(); // HOLD
        check("rd_hold_ack", 32'(b2.core_ack), 32'h1);
        check("rd_hold_rdata", 32'(b2.core_rdata), 32'h1234);
        b2.core_req = 1'b0;
        pad_din2 = 16'h5555;
        tick(); // IDLE
        check("rd_idle_ack", 32'(b2.core_ack), 32'h0);
        tick();
        check("rd_rdata_held", 32'(b2.core_rdata), 32'h1234);

        // Back-to-back writes with core_req held high
        b2.core_req = 1'b1; b2.core_we = 1'b1;
        b2.core_addr = 16'h0100; b2.core_wdata = 16'h1111;
        tick(); // SETUP
        b2.core_addr = 16'h0F0F; b2.core_wdata = 16'h2222;
        tick(); // ACCESS 1
        tick(); // ACCESS 2
        check("b2b_addr_stable", 32'(pad_addr2), 32'h0100);
        check("b2b_dout_stable", 32'(pad_dout2), 32'h1111);
        tick(); // HOLD
        check("b2b_ack1", 32'(b2.core_ack), 32'h1);
        tick(); // IDLE gap
        check("b2b_gap_ack_busy", {30'd0, b2.core_ack, b2.core_busy}, 32'h0);
        check("b2b_gap_addr", 32'(pad_addr2), 32'h0100);
        tick(); // SETUP of second
        check("b2b_second_busy", 32'(b2.core_busy), 32'h1);
        check("b2b_second_addr", 32'(pad_addr2), 32'h0F0F);
        check("b2b_second_dout", 32'(pad_dout2), 32'h2222);
        tick();
        tick();
        tick(); // HOLD
        check("b2b_ack2", 32'(b2.core_ack), 32'h1);
        check("b2b_rdata_untouched", 32'(b2.core_rdata), 32'h1234);
        b2.core_req = 1'b0;
        tick();

        // Reset held 3 cycles in the middle of a read access
        pad_din2 = 16'h7777;
        b2.core_req = 1'b1; b2.core_we = 1'b0; b2.core_addr = 16'h0030;
        tick(); // SETUP
        tick(); // ACCESS 1
        check("mid_acc_cs", 32'(pad_cs2), 32'h1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_strobes", {29'd0, pad_cs2, pad_we2, pad_oe2}, 32'h0);
            check("mrst_ack_busy", {30'd0, b2.core_ack, b2.core_busy}, 32'h0);
            check("mrst_rdata", 32'(b2.core_rdata), 32'h0);
            check("mrst_pad_addr_dout", {pad_addr2, pad_dout2}, 32'h0);
        end
        rst = 1'b0;
        b2.core_req = 1'b0;
        tick();
        check("mrst_after_ack_busy", {30'd0, b2.core_ack, b2.core_busy}, 32'h0);

        // Latency of WAIT_CYC = 1 and WAIT_CYC = 7 instances
        b1.core_req = 1'b1; b1.core_we = 1'b0; b1.core_addr = 16'h0040;
        b7.core_req = 1'b1; b7.core_we = 1'b0; b7.core_addr = 16'h0040;
        k1 = 0;
        k7 = 0;
        tick(); // accepting edge
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (b1.core_ack && k1 == 0) begin
                k1 = k;
                b1.core_req = 1'b0;
            end
            if (b7.core_ack && k7 == 0) begin
                k7 = k;
                b7.core_req = 1'b0;
            end
        end
        check("lat_wait1", 32'(k1), 32'd2);
        check("lat_wait7", 32'(k7), 32'd8);
        check("lat_busy_clear", {30'd0, b1.core_busy, b7.core_busy}, 32'h0);

`ifdef OFFCHIP_MEM_PARITY_EN
        // Read 0x0001 with par_in 0 -> odd total -> error
        pad_din2 = 16'h0001; par_in2 = 1'b0;
        b2.core_req = 1'b1; b2.core_we = 1'b0; b2.core_addr = 16'h0050;
        tick();
        tick();
        tick();
        tick(); // HOLD
        check("par_err_ack", {30'd0, b2.core_ack, perr2}, 32'b11);
        b2.core_req = 1'b0;
        tick();
        check("par_err_pulse_end", 32'(perr2), 32'h0);
        par_in2 = 1'b1;
        b2.core_req = 1'b1;
        tick();
        tick();
        tick();
        tick(); // HOLD
        check("par_ok_ack", {30'd0, b2.core_ack, perr2}, 32'b10);
        b2.core_req = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
